// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM encoding, pick result type and helpers
// for the Avalon-MM master arbiter (round-robin pick, byteenable width).
package arb_pkg;

  localparam int MAX_CH     = 8;
  localparam int DEF_DATA_W = 32;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t GRANT = 1'b1;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } pick_t;

  function automatic int be_w(input int data_w);
    return data_w / 8;
  endfunction

  localparam int BE_W = DEF_DATA_W / 8;

  // First requester at or after ptr, wrapping at num_ch.
  // Descending loop: the last hit written is the closest one.
  function automatic pick_t rr_pick(
    input logic [MAX_CH-1:0] req,
    input logic [2:0]        ptr,
    input int                num_ch
  );
    pick_t      p;
    logic [2:0] c;
    p = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      if (k < num_ch) begin
        c = 3'((int'(ptr) + k) % num_ch);
        if (req[c]) begin
          p.vld = 1'b1;
          p.idx = c;
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/avalon_master_arbiter_if.sv
// Avalon-MM bus bundle: NUM_CH upstream slave ports plus one master port.
// master = arbiter view (drives m_* and s_* responses); slave = environment.
interface avalon_master_arbiter_if
  import arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 26,
  parameter int DATA_W = 32
);
  localparam int BEW = be_w(DATA_W);

  logic [NUM_CH*ADDR_W-1:0] s_address;
  logic [NUM_CH-1:0]        s_read;
  logic [NUM_CH-1:0]        s_write;
  logic [NUM_CH*BEW-1:0]    s_byteenable;
  logic [NUM_CH*DATA_W-1:0] s_writedata;
  logic [NUM_CH-1:0]        s_waitrequest;
  logic [DATA_W-1:0]        s_readdata;
  logic [NUM_CH-1:0]        s_readdatavalid;

  logic [ADDR_W-1:0]        m_address;
  logic                     m_read;
  logic                     m_write;
  logic [BEW-1:0]           m_byteenable;
  logic [DATA_W-1:0]        m_writedata;
  logic                     m_waitrequest;
  logic [DATA_W-1:0]        m_readdata;
  logic                     m_readdatavalid;

  modport master (
    input  s_address, s_read, s_write,
    input  s_byteenable, s_writedata,
    output s_waitrequest, s_readdata,
    output s_readdatavalid,
    output m_address, m_read, m_write,
    output m_byteenable, m_writedata,
    input  m_waitrequest, m_readdata,
    input  m_readdatavalid
  );

  modport slave (
    output s_address, s_read, s_write,
    output s_byteenable, s_writedata,
    input  s_waitrequest, s_readdata,
    input  s_readdatavalid,
    input  m_address, m_read, m_write,
    input  m_byteenable, m_writedata,
    output m_waitrequest, m_readdata,
    output m_readdatavalid
  );

endinterface

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: read-owner tag FIFO (push/pop/din/dout/full/empty/count).
// DEPTH is a power of two; push while full is taken when a pop coincides.
module arb_tag_fifo #(
  parameter int TAG_W = 2,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [TAG_W-1:0]       din,
  output logic [TAG_W-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push)
                  - (AW+1)'(do_pop);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/avalon_master_arbiter.sv
// avalon_master_arbiter: merges NUM_CH Avalon-MM masters onto one SDRAM port.
// Ports: clock, reset (async low), bus (if.master), outstanding, rsp_error.
module avalon_master_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 8,
  parameter int ARB_MODE  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  avalon_master_arbiter_if.master    bus,
  output logic [$clog2(MAX_OUTST):0] outstanding,
  output logic                       rsp_error
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int BEW  = be_w(DATA_W);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   owner_q, owner_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic              rsp_error_q, rsp_error_d;

  logic              fifo_full, fifo_empty;
  logic [CH_W-1:0]   fifo_dout;
  logic              push, pop, accept;
  logic              cmd_wr, cmd_rd;
  logic [NUM_CH-1:0] elig;
  pick_t             pick;

  // Reads need a free tag slot; writes are always eligible.
  assign elig = bus.s_write
              | (bus.s_read & {NUM_CH{~fifo_full}});

  assign pick = rr_pick(MAX_CH'(elig),
                        (ARB_MODE == 1) ? 3'd0 : 3'(ptr_q),
                        NUM_CH);

  always_comb begin
    bus.m_address    = bus.s_address[owner_q*ADDR_W +: ADDR_W];
    bus.m_byteenable = bus.s_byteenable[owner_q*BEW +: BEW];
    bus.m_writedata  = bus.s_writedata[owner_q*DATA_W +: DATA_W];
    // Read+write together is treated as a write.
    cmd_wr = (state_q == GRANT) & bus.s_write[owner_q];
    cmd_rd = (state_q == GRANT) & bus.s_read[owner_q]
           & ~bus.s_write[owner_q] & ~fifo_full;
    bus.m_write = cmd_wr;
    bus.m_read  = cmd_rd;
    bus.s_waitrequest = '1;
    if (state_q == GRANT)
      bus.s_waitrequest[owner_q] = bus.m_waitrequest;
  end

  assign accept = (cmd_wr | cmd_rd) & ~bus.m_waitrequest;
  assign push   = accept & cmd_rd;
  assign pop    = bus.m_readdatavalid & ~fifo_empty;

  assign bus.s_readdata      = bus.m_readdata;
  assign bus.s_readdatavalid = pop ? (NUM_CH'(1) << fifo_dout) : '0;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (pick.vld) begin
          owner_d = CH_W'(pick.idx);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          state_d = IDLE;
          ptr_d   = (owner_q == CH_W'(NUM_CH - 1))
                  ? '0 : owner_q + 1'b1;
        end else if (!(cmd_wr | cmd_rd)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Returning data with no tag is unmatched and latches the error.
  assign rsp_error_d = rsp_error_q
                     | (bus.m_readdatavalid & fifo_empty);
  assign rsp_error   = rsp_error_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  arb_tag_fifo #(
    .TAG_W (CH_W),
    .DEPTH (MAX_OUTST)
  ) u_tag_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (owner_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

endmodule
